// File: rtl/logic_healthcare_system_controller_if.sv
// Bundles the patient-monitor abnormality flags and the registered warning code.
interface logic_healthcare_system_controller_if;
  logic       presureAbnormality;
  logic       bloodAbnormality;
  logic       fallDetected;
  logic       temperatureAbnormality;
  logic [1:0] nervousAbnormality;
  logic [2:0] abnormaliryWarning;

  modport master (
    output presureAbnormality,
    output bloodAbnormality,
    output fallDetected,
    output temperatureAbnormality,
    output nervousAbnormality,
    input  abnormaliryWarning
  );

  modport slave (
    input  presureAbnormality,
    input  bloodAbnormality,
    input  fallDetected,
    input  temperatureAbnormality,
    input  nervousAbnormality,
    output abnormaliryWarning
  );
endinterface

// File: rtl/logic_healthcare_system_controller.sv
// Priority-encodes patient abnormality flags into a warning code; a raised code wins at once,
// a lowered code only takes effect after the current code has been held for three more edges.
module logic_healthcare_system_controller (
  input logic                                clock,
  input logic                                resetN,
  logic_healthcare_system_controller_if.slave hcIf
);

  logic [2:0] candidate;
  logic [2:0] warnQ, warnD;
  logic [1:0] holdCntQ, holdCntD;

  always_comb begin
    candidate = 3'd0;
    if (hcIf.fallDetected) begin
      candidate = 3'd7;
    end else if (hcIf.nervousAbnormality == 2'd3) begin
      candidate = 3'd6;
    end else if (hcIf.nervousAbnormality == 2'd2) begin
      candidate = 3'd5;
    end else if (hcIf.presureAbnormality) begin
      candidate = 3'd4;
    end else if (hcIf.bloodAbnormality) begin
      candidate = 3'd3;
    end else if (hcIf.temperatureAbnormality) begin
      candidate = 3'd2;
    end else if (hcIf.nervousAbnormality == 2'd1) begin
      candidate = 3'd1;
    end
  end

  always_comb begin
    warnD    = warnQ;
    holdCntD = holdCntQ;
    if (candidate >= warnQ || holdCntQ == 2'd0) begin
      // Equal codes also land here, which re-arms the hold window.
      warnD    = candidate;
      holdCntD = (candidate != 3'd0) ? 2'd3 : 2'd0;
    end else begin
      holdCntD = holdCntQ - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      warnQ    <= 3'd0;
      holdCntQ <= 2'd0;
    end else begin
      warnQ    <= warnD;
      holdCntQ <= holdCntD;
    end
  end

  assign hcIf.abnormaliryWarning = warnQ;

endmodule

// File: tb/tb_logic_healthcare_system_controller.sv
// Directed vector bench for the healthcare warning controller.
module tb_logic_healthcare_system_controller;

  logic clock;
  logic resetN;
  int   nChecks;
  int   nFails;

  logic_healthcare_system_controller_if hcIf ();

  logic_healthcare_system_controller dut (
    .clock  (clock),
    .resetN (resetN),
    .hcIf   (hcIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       fall;
    logic [1:0] nerv;
    logic       pres;
    logic       blood;
    logic       temp;
    logic [2:0] expW;
  } vec_t;

  localparam int NumVecs = 27;
  vec_t vecs [NumVecs];

  function automatic vec_t mk(input logic f, input logic [1:0] n, input logic p, input logic b,
                              input logic t, input logic [2:0] e);
    vec_t v;
    v.fall  = f;
    v.nerv  = n;
    v.pres  = p;
    v.blood = b;
    v.temp  = t;
    v.expW  = e;
    return v;
  endfunction

  // Hand-written reference encoding of the priority list.
  function automatic logic [2:0] prio(input logic f, input logic [1:0] n, input logic p,
                                      input logic b, input logic t);
    if (f) return 3'd7;
    if (n == 2'd3) return 3'd6;
    if (n == 2'd2) return 3'd5;
    if (p) return 3'd4;
    if (b) return 3'd3;
    if (t) return 3'd2;
    if (n == 2'd1) return 3'd1;
    return 3'd0;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [1:0] n, input logic p, input logic b,
                       input logic t);
    hcIf.fallDetected           = f;
    hcIf.nervousAbnormality     = n;
    hcIf.presureAbnormality     = p;
    hcIf.bloodAbnormality       = b;
    hcIf.temperatureAbnormality = t;
  endtask

  task automatic stepCheck(input string name, input vec_t v);
    @(negedge clock);
    drive(v.fall, v.nerv, v.pres, v.blood, v.temp);
    @(posedge clock);
    #1;
    check(name, hcIf.abnormaliryWarning, v.expW);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    resetN  = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    //            fall nerv  pres  blood temp  expW
    vecs[0]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);
    vecs[1]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);
    vecs[2]  = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3'd4);
    vecs[3]  = mk(1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 3'd5);
    vecs[4]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd5);
    vecs[5]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd5);
    vecs[6]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd5);
    vecs[7]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    vecs[8]  = mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd2);
    vecs[9]  = mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd3);
    vecs[10] = mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[11] = mk(1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 3'd3);
    vecs[12] = mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[13] = mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[14] = mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd3);
    vecs[15] = mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 3'd1);
    vecs[16] = mk(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 3'd6);
    vecs[17] = mk(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 3'd7);
    vecs[18] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[19] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[20] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[21] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);
    vecs[22] = mk(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[23] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[24] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[25] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd7);
    vecs[26] = mk(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 3'd4);

    #1;
    check("resetValue", hcIf.abnormaliryWarning, 3'd0);
    @(posedge clock);
    #1;
    check("resetHeldOverEdge", hcIf.abnormaliryWarning, 3'd0);
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < NumVecs; i++) begin
      stepCheck($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted between edges while the output reads 7, mid-hold.
    stepCheck("fallBeforeReset", mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 3'd7));
    stepCheck("holdBeforeReset", mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd7));
    #2;
    resetN = 1'b0;
    #1;
    check("asyncResetClears", hcIf.abnormaliryWarning, 3'd0);
    @(posedge clock);
    #1;
    check("resetStaysLow", hcIf.abnormaliryWarning, 3'd0);
    @(negedge clock);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    resetN = 1'b1;
    #1;
    check("releaseBeforeEdge", hcIf.abnormaliryWarning, 3'd0);
    @(posedge clock);
    #1;
    check("holdAborted", hcIf.abnormaliryWarning, 3'd0);
    stepCheck("afterRelease", mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd2));

    // Priority sweep: every input combination loaded from a freshly reset state.
    for (int c = 0; c < 64; c++) begin
      logic [5:0] bits;
      bits = c[5:0];
      @(negedge clock);
      resetN = 1'b0;
      #1;
      check($sformatf("sweepReset%0d", c), hcIf.abnormaliryWarning, 3'd0);
      @(negedge clock);
      resetN = 1'b1;
      drive(bits[5], bits[4:3], bits[2], bits[1], bits[0]);
      @(posedge clock);
      #1;
      check($sformatf("sweepPrio%0d", c), hcIf.abnormaliryWarning,
            prio(bits[5], bits[4:3], bits[2], bits[1], bits[0]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/logic_healthcare_system_controller.md
LOGIC_HEALTHCARE_SYSTEM_CONTROLLER -- requirements
Module: logic_healthcare_system_controller

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port presureAbnormality, input, 1 bit: blood-pressure abnormality flag, 1 = abnormal.
REQ-004 The block SHALL have the port bloodAbnormality, input, 1 bit: blood-chemistry abnormality flag, 1 = abnormal.
REQ-005 The block SHALL have the port fallDetected, input, 1 bit: patient-fall flag, 1 = fall detected.
REQ-006 The block SHALL have the port temperatureAbnormality, input, 1 bit: temperature abnormality flag, 1 = abnormal.
REQ-007 The block SHALL have the port nervousAbnormality, input, 2 bits: nervous-system severity, 0 = normal, 1/2/3 = increasing severity.
REQ-008 The block SHALL have the port abnormaliryWarning, output, 3 bits: registered warning code (spelling fixed as shown).
REQ-009 The block SHALL treat all inputs as synchronous to clock and SHALL NOT add input synchronizers.

Function
REQ-010 The block SHALL compute a combinational candidate code N each cycle with fixed priority, highest first: fallDetected=1 -> 7; nervousAbnormality=3 -> 6; nervousAbnormality=2 -> 5; presureAbnormality=1 -> 4; bloodAbnormality=1 -> 3; temperatureAbnormality=1 -> 2; nervousAbnormality=1 -> 1; otherwise 0.
REQ-011 When several abnormalities are active at once, the block SHALL use only the highest-priority one, with no merging or accumulation.
REQ-012 The block SHALL hold internal state W (the abnormaliryWarning register, 3 bits) and holdCnt (2 bits).
REQ-013 When N >= W at a rising edge, the block SHALL set W to N, and SHALL set holdCnt to 3 if N != 0, else to 0.
REQ-014 When N < W and holdCnt != 0 at a rising edge, the block SHALL keep W and decrement holdCnt by 1.
REQ-015 When N < W and holdCnt = 0 at a rising edge, the block SHALL set W to N, and SHALL set holdCnt to 3 if N != 0, else to 0.
REQ-016 A higher-priority code SHALL override the output on the next rising edge, with 1-cycle latency and no hold delay.
REQ-017 A lower-priority code or 0 SHALL appear only after the current code has been held for 3 further edges, so W changes on the 4th edge after N first drops.
REQ-018 If N rises back to equal W while W is being held, the block SHALL reload holdCnt to 3 and keep W.
REQ-019 abnormaliryWarning SHALL be driven directly from W with no combinational path from the inputs.

Reset
REQ-020 While resetN = 0, the block SHALL force W = 0 and holdCnt = 0 immediately, independent of clock.
REQ-021 An assertion of resetN mid-hold SHALL abort the hold, and the output SHALL read 0 during reset.
REQ-022 After resetN rises, the first rising edge SHALL load W = N under REQ-013.
REQ-023 The block SHALL have no other state and SHALL require no initialisation beyond reset.

Verification
REQ-024 Scenario: reset released, presureAbnormality=1, all other inputs 0 -> abnormaliryWarning = 4 after the first rising edge, stable thereafter.
REQ-025 Scenario: presureAbnormality=1, then temperatureAbnormality=1 added -> output stays 4, because temperature is lower priority.
REQ-026 Scenario: presureAbnormality=1, bloodAbnormality=1, temperatureAbnormality=0, nervousAbnormality=2 -> output 5 on the next edge.
REQ-027 Scenario: output at 5, then all inputs cleared -> output stays 5 for 3 edges and is 0 on the 4th edge.
REQ-028 Scenario: output at 4 holding, fallDetected=1 pulsed for one cycle -> output 7 on the next edge, then held 3 edges, then falls to the current N.
REQ-029 Scenario: resetN driven to 0 between clock edges while the output is 7 -> output 0 immediately, and it stays 0 until the first edge after release.
